program_loader: RTL and testbench
=================================

# program_loader

Boot-time controller that owns the single memory port between an external byte-stream loader and the CPU core. After reset, or on a `LOAD_START` pulse, it holds the CPU in reset and accepts a framed program stream (length, payload, checksum). It writes the payload to memory addresses 0..N-1, verifies the checksum, then hands the memory port back to the CPU and releases the CPU reset. It sits between the CPU's memory-request signals and `memory_unit`.

## Interface
Parameters: none. Widths come from the shared package: `DEFAULT_TYPE` is `REGSIZE` = 8 bits.

Ports:
- `CLOCK`  in  1  sole clock, rising-edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `LOAD_START`  in  1  single-cycle request to (re)start a load; legal in any state.
- `in_valid`  in  1  loader byte valid.
- `in_data`  in  `DEFAULT_TYPE`  loader byte.
- `in_ready`  out  1  byte accepted on an edge where `in_valid && in_ready`.
- `cpu_address`  in  `DEFAULT_TYPE`  CPU memory address request.
- `cpu_rw_flag`  in  `MEMORY_FLAG_TYPE`  CPU memory command.
- `cpu_write_value`  in  `DEFAULT_TYPE`  CPU write data.
- `address`  out  `DEFAULT_TYPE`  to `memory_unit`.
- `rw_flag`  out  `MEMORY_FLAG_TYPE`  to `memory_unit`.
- `write_memory_value`  out  `DEFAULT_TYPE`  to `memory_unit`.
- `cpu_reset`  out  1  drives the CPU's synchronous `RESET`.
- `load_error`  out  1  checksum mismatch; sticky until the next `LOAD_START`.
- `load_count`  out  `DEFAULT_TYPE`  number of payload bytes written so far.

## Operation
States:
- `LD_IDLE`: reset state. `cpu_reset` = 1. `LOAD_START` -> `LD_HEADER`.
- `LD_HEADER`: `in_ready` = 1. On an accepted byte, latch N = `in_data` and clear the checksum.
  - N = 0 -> `LD_CHECK`.
  - Otherwise -> `LD_WRITE`.
- `LD_WRITE`: `in_ready` = 1. On each accepted byte:
  - Drive `address` = `load_count`, `rw_flag` = `MEMORY_WRITE`, `write_memory_value` = `in_data` combinationally in that same cycle.
  - `load_count`++ and sum += `in_data` (mod 256).
  - When `load_count` + 1 == N -> `LD_CHECK`.
  - Cycles with no accepted byte drive `MEMORY_STAY`, address 0, value 0.
- `LD_CHECK`: `in_ready` = 1. On an accepted byte:
  - Byte == sum -> `LD_RELEASE`.
  - Otherwise -> `LD_ERROR`, setting `load_error`.
- `LD_RELEASE`: exactly one cycle. `cpu_reset` = 1, memory port muxed to the CPU, then -> `LD_RUN`.
- `LD_RUN`: `cpu_reset` = 0. `address`, `rw_flag` and `write_memory_value` pass through the `cpu_*` inputs unchanged.
- `LD_ERROR`: `cpu_reset` = 1, `MEMORY_STAY`. Waits for `LOAD_START`.

Rules that apply across states:
- `cpu_reset` = 1 in every state except `LD_RUN`. It is decoded from the state register, never from inputs.
- In every non-RUN state the CPU's memory inputs are ignored.
- `LOAD_START` in any state, including mid-payload and `LD_RUN`, goes to `LD_HEADER` next cycle and clears `load_count`, sum and `load_error`. It takes priority over a simultaneous accepted byte; that byte is discarded and no memory write occurs that cycle.
- `in_valid` is ignored whenever `in_ready` = 0. `in_ready` must not depend on `in_valid`.
- Maximum N = 255, written to addresses 0..254. `load_count` never wraps.
- Sum arithmetic is 8-bit modulo; carry is discarded.

## Timing
- Reset values:
  - state `LD_IDLE`, `cpu_reset` = 1, `in_ready` = 0, `load_error` = 0, `load_count` = 0.
  - `rw_flag` = `MEMORY_STAY`, `address` = 0, `write_memory_value` = 0.
- `RESET` asserted at any point (including mid-load or during RUN) forces these values immediately and asynchronously.
- Throughput is one byte per cycle. A payload write reaches memory on the same edge that accepts the byte.
- Latency from the edge accepting a good checksum:
  - +1 cycle: `LD_RELEASE`.
  - +2 cycles: `LD_RUN`; `cpu_reset` falls.
  - The CPU therefore samples reset high on at least one edge after the final write and fetches address 0 on its first post-reset fetch.
- `LOAD_START` during `LD_RUN` raises `cpu_reset` on the next cycle.
- Any CPU memory request issued in that same cycle still passes through; it is the last one.

## Structure
- Add `LOADER_STATE_TYPE` (`LD_IDLE`, `LD_HEADER`, `LD_WRITE`, `LD_CHECK`, `LD_RELEASE`, `LD_RUN`, `LD_ERROR`) to `typedef_collection.sv`, alongside the existing `DEFAULT_TYPE` and `MEMORY_FLAG_TYPE`.
- Sub-module `loader_memory_mux` (combinational): selects between the CPU request and the loader write based on state.
- State, count, N and sum registers live in one `always_ff @(posedge CLOCK or posedge RESET)` block.
- Next-state and next-value logic is `always_comb`.

## Test plan
- Stream 3, 0x01, 0x02, 0x03, checksum 0x06 -> writes mem[0..2] = 1, 2, 3 on consecutive edges; `cpu_reset` falls exactly 2 cycles after the checksum edge; the CPU's first fetch is at address 0.
- Stream 2, 0x10, 0x20, checksum 0x31 -> `LD_ERROR`, `load_error` = 1, `cpu_reset` stays 1, no further writes; `LOAD_START` then clears `load_error`.
- Stream 0 then checksum 0x00 -> no memory writes, `cpu_reset` released 2 cycles later.
- Toggle `in_valid` randomly during the payload -> each byte is written exactly once at the correct address; idle cycles drive `MEMORY_STAY`.
- `LOAD_START` together with the 2nd payload byte, then a fresh stream of length 1 -> the colliding byte is not written; the new byte lands at address 0.
- Assert `RESET` during `LD_WRITE` and again during `LD_RUN` -> all outputs take their reset values without waiting for a clock edge; stays in `LD_IDLE` until `LOAD_START`.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared widths, memory command encoding and loader state type for the boot loader.
package program_loader_pkg;

  localparam int REGSIZE = 8;

  typedef logic [REGSIZE-1:0] DEFAULT_TYPE;

  typedef enum logic [1:0] {
    MEMORY_STAY  = 2'd0,
    MEMORY_READ  = 2'd1,
    MEMORY_WRITE = 2'd2
  } MEMORY_FLAG_TYPE;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_HEADER  = 3'd1,
    LD_WRITE   = 3'd2,
    LD_CHECK   = 3'd3,
    LD_RELEASE = 3'd4,
    LD_RUN     = 3'd5,
    LD_ERROR   = 3'd6
  } LOADER_STATE_TYPE;

  // The CPU owns the memory port from the release cycle onward.
  function automatic logic cpu_owns_port(LOADER_STATE_TYPE s);
    return (s == LD_RELEASE) || (s == LD_RUN);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream, CPU-request and memory-port signals of the program loader.
interface program_loader_if;
  import program_loader_pkg::*;

  logic            in_valid;
  DEFAULT_TYPE     in_data;
  logic            in_ready;
  DEFAULT_TYPE     cpu_address;
  MEMORY_FLAG_TYPE cpu_rw_flag;
  DEFAULT_TYPE     cpu_write_value;
  DEFAULT_TYPE     address;
  MEMORY_FLAG_TYPE rw_flag;
  DEFAULT_TYPE     write_memory_value;

  modport slave (
    input  in_valid, in_data, cpu_address, cpu_rw_flag, cpu_write_value,
    output in_ready, address, rw_flag, write_memory_value
  );

  modport master (
    output in_valid, in_data, cpu_address, cpu_rw_flag, cpu_write_value,
    input  in_ready, address, rw_flag, write_memory_value
  );

endinterface

// File: rtl/program_loader_memory_mux.sv
// Combinational selection of the memory port between the CPU and the loader write path.
module loader_memory_mux
  import program_loader_pkg::*;
(
  input  logic            cpu_sel_i,
  input  logic            ld_write_i,
  input  DEFAULT_TYPE     ld_address_i,
  input  DEFAULT_TYPE     ld_value_i,
  input  DEFAULT_TYPE     cpu_address_i,
  input  MEMORY_FLAG_TYPE cpu_rw_flag_i,
  input  DEFAULT_TYPE     cpu_write_value_i,
  output DEFAULT_TYPE     address_o,
  output MEMORY_FLAG_TYPE rw_flag_o,
  output DEFAULT_TYPE     write_memory_value_o
);

  always_comb begin
    address_o            = '0;
    rw_flag_o            = MEMORY_STAY;
    write_memory_value_o = '0;
    if (cpu_sel_i) begin
      address_o            = cpu_address_i;
      rw_flag_o            = cpu_rw_flag_i;
      write_memory_value_o = cpu_write_value_i;
    end else if (ld_write_i) begin
      address_o            = ld_address_i;
      rw_flag_o            = MEMORY_WRITE;
      write_memory_value_o = ld_value_i;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: holds the CPU in reset, writes a framed byte stream to memory 0..N-1, verifies its checksum, then releases the CPU.
module program_loader
  import program_loader_pkg::*;
(
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             LOAD_START,
  program_loader_if.slave  bus,
  output logic             cpu_reset,
  output logic             load_error,
  output DEFAULT_TYPE      load_count
);

  LOADER_STATE_TYPE state_q, state_d;
  DEFAULT_TYPE      count_q, count_d;
  DEFAULT_TYPE      len_q, len_d;
  DEFAULT_TYPE      sum_q, sum_d;
  logic             error_q, error_d;

  logic in_ready;
  logic accept;
  logic ld_write;

  // Ready is a pure state decode so it never depends on in_valid.
  assign in_ready = (state_q == LD_HEADER) || (state_q == LD_WRITE) || (state_q == LD_CHECK);
  assign accept   = bus.in_valid && in_ready;
  assign ld_write = accept && !LOAD_START && (state_q == LD_WRITE);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= LD_IDLE;
      count_q <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    sum_d   = sum_q;
    error_d = error_q;
    if (LOAD_START) begin
      // A restart discards any byte presented alongside it.
      state_d = LD_HEADER;
      count_d = '0;
      sum_d   = '0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        LD_HEADER: begin
          if (accept) begin
            len_d   = bus.in_data;
            sum_d   = '0;
            state_d = (bus.in_data == '0) ? LD_CHECK : LD_WRITE;
          end
        end
        LD_WRITE: begin
          if (accept) begin
            count_d = count_q + DEFAULT_TYPE'(1);
            sum_d   = sum_q + bus.in_data;
            if (count_q + DEFAULT_TYPE'(1) == len_q) begin
              state_d = LD_CHECK;
            end
          end
        end
        LD_CHECK: begin
          if (accept) begin
            if (bus.in_data == sum_q) begin
              state_d = LD_RELEASE;
            end else begin
              state_d = LD_ERROR;
              error_d = 1'b1;
            end
          end
        end
        LD_RELEASE: state_d = LD_RUN;
        default:    state_d = state_q;
      endcase
    end
  end

  loader_memory_mux u_mux (
    .cpu_sel_i            (cpu_owns_port(state_q)),
    .ld_write_i           (ld_write),
    .ld_address_i         (count_q),
    .ld_value_i           (bus.in_data),
    .cpu_address_i        (bus.cpu_address),
    .cpu_rw_flag_i        (bus.cpu_rw_flag),
    .cpu_write_value_i    (bus.cpu_write_value),
    .address_o            (bus.address),
    .rw_flag_o            (bus.rw_flag),
    .write_memory_value_o (bus.write_memory_value)
  );

  assign bus.in_ready = in_ready;
  assign cpu_reset    = (state_q != LD_RUN);
  assign load_error   = error_q;
  assign load_count   = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; expected memory writes are queued and checked when they appear on the port.
module tb_program_loader;
  import program_loader_pkg::*;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        LOAD_START;
  logic        cpu_reset;
  logic        load_error;
  DEFAULT_TYPE load_count;

  program_loader_if bus();

  always #5 CLOCK = ~CLOCK;

  program_loader dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .LOAD_START (LOAD_START),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .load_error (load_error),
    .load_count (load_count)
  );

  int checks   = 0;
  int failures = 0;
  logic [15:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every loader write seen on the port must match the oldest queued expectation.
  always @(negedge CLOCK) begin
    if (bus.rw_flag == MEMORY_WRITE && cpu_reset) begin
      if (sb.size() == 0) begin
        check("wr_expected_pending", 32'(sb.size()), 32'd1);
      end else begin
        logic [15:0] exp_wr;
        exp_wr = sb.pop_front();
        check("wr_addr_data", {16'h0, bus.address, bus.write_memory_value}, {16'h0, exp_wr});
        $display("write addr=0x%02h data=0x%02h", bus.address, bus.write_memory_value);
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
    check({tag, "_load_count"}, 32'(load_count), 32'd0);
    check({tag, "_rw_flag"}, 32'(bus.rw_flag), 32'(MEMORY_STAY));
    check({tag, "_address"}, 32'(bus.address), 32'd0);
    check({tag, "_wdata"}, 32'(bus.write_memory_value), 32'd0);
  endtask

  initial begin
    logic [7:0] sum;
    logic [7:0] b;
    logic       v;
    int         tries;
    bit         sent;

    RESET               = 1'b1;
    LOAD_START          = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_data         = '0;
    bus.cpu_address     = 8'h42;
    bus.cpu_rw_flag     = MEMORY_READ;
    bus.cpu_write_value = 8'h99;
    #1;
    check_reset_outputs("por");
    tick();
    RESET = 1'b0;
    tick();
    tick();
    check("idle_in_ready", 32'(bus.in_ready), 32'd0);
    check("idle_cpu_reset", 32'(cpu_reset), 32'd1);

    // Good 3-byte program
    pulse_start();
    check("hdr_in_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'd3);
    sb.push_back({8'd0, 8'h01});
    sb.push_back({8'd1, 8'h02});
    sb.push_back({8'd2, 8'h03});
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check("t1_count", 32'(load_count), 32'd3);
    send_byte(8'h06);
    check("t1_release_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t1_release_rw_pass", 32'(bus.rw_flag), 32'(MEMORY_READ));
    check("t1_release_addr_pass", 32'(bus.address), 32'h42);
    tick();
    check("t1_run_cpu_reset", 32'(cpu_reset), 32'd0);
    bus.cpu_address = 8'h00;
    #1;
    check("t1_first_fetch", 32'(bus.address), 32'h00);
    check("t1_load_error", 32'(load_error), 32'd0);
    $display("t1 done count=%0d", load_count);

    // Bad checksum
    pulse_start();
    bus.cpu_address = 8'h42;
    check("t2_cpu_reset_raised", 32'(cpu_reset), 32'd1);
    check("t2_count_clear", 32'(load_count), 32'd0);
    send_byte(8'd2);
    sb.push_back({8'd0, 8'h10});
    sb.push_back({8'd1, 8'h20});
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h31);
    check("t2_load_error", 32'(load_error), 32'd1);
    check("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t2_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    tick();
    tick();
    check("t2_err_stay", 32'(bus.rw_flag), 32'(MEMORY_STAY));
    check("t2_err_sticky", 32'(load_error), 32'd1);
    bus.in_valid = 1'b0;
    pulse_start();
    check("t2_error_cleared", 32'(load_error), 32'd0);
    $display("t2 done load_error=%0d", load_error);

    // Empty program
    send_byte(8'd0);
    check("t3_count", 32'(load_count), 32'd0);
    send_byte(8'h00);
    check("t3_release_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    check("t3_run_cpu_reset", 32'(cpu_reset), 32'd0);
    $display("t3 done");

    // Gappy payload
    pulse_start();
    send_byte(8'd5);
    sum = 8'h00;
    for (int i = 0; i < 5; i++) begin
      b     = 8'hA0 + 8'(i);
      sent  = 1'b0;
      tries = 0;
      while (!sent) begin
        v = (tries >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.in_valid = v;
        bus.in_data  = b;
        if (v) sb.push_back({8'(i), b});
        #1;
        if (!v) begin
          check("t4_idle_stay", 32'(bus.rw_flag), 32'(MEMORY_STAY));
          check("t4_idle_addr", 32'(bus.address), 32'd0);
        end
        @(posedge CLOCK);
        #1;
        tries++;
        if (v) sent = 1'b1;
      end
      bus.in_valid = 1'b0;
      sum = sum + b;
    end
    check("t4_count", 32'(load_count), 32'd5);
    send_byte(sum);
    tick();
    check("t4_run_cpu_reset", 32'(cpu_reset), 32'd0);
    $display("t4 done sum=0x%02h", sum);

    // Restart colliding with the second payload byte
    pulse_start();
    send_byte(8'd4);
    sb.push_back({8'd0, 8'h11});
    send_byte(8'h11);
    LOAD_START   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h22;
    #1;
    check("t5_collide_no_write", 32'(bus.rw_flag), 32'(MEMORY_STAY));
    tick();
    LOAD_START   = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_count_clear", 32'(load_count), 32'd0);
    check("t5_header_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'd1);
    sb.push_back({8'd0, 8'h5A});
    send_byte(8'h5A);
    send_byte(8'h5A);
    check("t5_release_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    check("t5_run_cpu_reset", 32'(cpu_reset), 32'd0);
    $display("t5 done");

    // Asynchronous reset mid-write
    pulse_start();
    send_byte(8'd3);
    sb.push_back({8'd0, 8'h01});
    send_byte(8'h01);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h02;
    #1;
    RESET = 1'b1;
    #1;
    check_reset_outputs("t6_write");
    bus.in_valid = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    tick();
    tick();
    check("t6_idle_in_ready", 32'(bus.in_ready), 32'd0);
    check("t6_idle_cpu_reset", 32'(cpu_reset), 32'd1);
    pulse_start();
    send_byte(8'd1);
    sb.push_back({8'd0, 8'h77});
    send_byte(8'h77);
    send_byte(8'h77);
    tick();
    check("t6_run_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t6_run_pass", 32'(bus.address), 32'h42);
    #1;
    RESET = 1'b1;
    #1;
    check_reset_outputs("t6_run");
    tick();
    RESET = 1'b0;
    tick();
    check("t6_stays_idle", 32'(bus.in_ready), 32'd0);
    $display("t6 done");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
